// File: rtl/disp_pkg.sv
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared constants, FSM state type and BCD helper functions for the
//            display scan controller slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam int         BCD_MAX    = 9999;
    localparam logic [3:0] SEL_RESET  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Double-dabble correction step: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [4*NUM_DIGITS-1:0] bcd_adjust(input logic [4*NUM_DIGITS-1:0] bcd);
        logic [4*NUM_DIGITS-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

    // Bit i is set when digit i and every digit above it are zero.
    // The units digit (bit 0) is never flagged so a value of 0 still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] bcd);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd[4*i +: 4] == 4'd0);
            m[i]       = zero_above;
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential double-dabble binary-to-BCD converter. A start pulse
//            loads the operand; BIN_W shift cycles follow. done is high during
//            the final shift cycle, so bcd holds the result from the next cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BIN_W-1:0]        bin,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int                 BCD_W      = 4 * NUM_DIGITS;
    localparam int                 CNT_W      = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0]   c_CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(1);

    logic [BIN_W-1:0] r_bin;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [BCD_W-1:0] w_adj;

    assign w_adj = bcd_adjust(r_bcd);
    assign done  = r_busy & (r_cnt == c_CNT_LAST);
    assign bcd   = r_bcd;

    // Load on start, then adjust-and-shift one binary bit into the BCD field per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_bin  <= bin;
            r_bcd  <= '0;
            r_cnt  <= c_CNT_LOAD;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
            r_bin <= {r_bin[BIN_W-2:0], 1'b0};
            r_cnt <= r_cnt - c_CNT_LAST;
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
// ============================================================================
// Module   : disp_scan_ctrl
// Brief    : Accepts a binary value over valid/ready, converts it to four BCD
//            digits and time-multiplexes them onto a 4-digit common display.
//            Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most
//            significant non-zero digit (units digit always shown).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BIN_W    = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    output logic [3:0]       digit,
    output logic [3:0]       dig_sel,
    output logic             ovf
);

    localparam int               BCD_W      = 4 * NUM_DIGITS;
    localparam int               IDX_W      = $clog2(NUM_DIGITS);
    localparam int               PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] c_PRE_LAST = PRE_W'(SCAN_DIV - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_start;
    logic                  w_commit;
    logic                  w_conv_done;
    logic                  w_bin_ovf;
    logic [BIN_W-1:0]      w_bin_clamped;
    logic [BCD_W-1:0]      w_bcd;
    logic [BCD_W-1:0]      r_disp;
    logic [PRE_W-1:0]      r_pre;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_idx_d;
    logic [NUM_DIGITS-1:0] w_sel_nxt;
`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] r_blank;
`endif

    // Values beyond four decimal digits are saturated and flagged.
    assign w_bin_ovf     = (32'(in_bin) > 32'(BCD_MAX));
    assign w_bin_clamped = w_bin_ovf ? BIN_W'(BCD_MAX) : in_bin;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_start),
        .bin   (w_bin_clamped),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and handshake decode; in_ready is high only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_start     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                if (w_conv_done) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Overflow flag refreshes on every accept and holds until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (w_start) begin
            ovf <= w_bin_ovf;
        end
    end

    // Display register (and blank mask when enabled) load together on COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp  <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            r_blank <= SEL_RESET;
`endif
        end else if (w_commit) begin
            r_disp  <= w_bcd;
`ifdef LEADING_ZERO_BLANK_EN
            r_blank <= lead_zero_mask(w_bcd);
`endif
        end
    end

    // Prescaler and scan index run free of the conversion FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre <= '0;
            r_idx <= r_idx + 1'b1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Active-low one-hot enable from the delayed index, with blanked digits forced off.
`ifdef LEADING_ZERO_BLANK_EN
    assign w_sel_nxt = ~(NUM_DIGITS'(1) << r_idx_d) | r_blank;
`else
    assign w_sel_nxt = ~(NUM_DIGITS'(1) << r_idx_d);
`endif

    // Digit output follows the index; the enable trails it by one cycle to match the decoder register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit   <= 4'd0;
            r_idx_d <= '0;
            dig_sel <= SEL_RESET;
        end else begin
            digit   <= r_disp[4*r_idx +: 4];
            r_idx_d <= r_idx;
            dig_sel <= w_sel_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
// ============================================================================
// Module   : tb_disp_scan_ctrl
// Brief    : Self-checking bench for disp_scan_ctrl with a fast scan divider.
//            A per-cycle monitor checks digit/dig_sel against a display model
//            fed by a queue of expected commits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_scan_ctrl;

    localparam int BIN_W    = 14;
    localparam int SCAN_DIV = 4;
    localparam int LAT      = BIN_W + 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic [BIN_W-1:0] in_bin   = '0;
    logic             in_ready;
    logic [3:0]       digit;
    logic [3:0]       dig_sel;
    logic             ovf;

    int n_assert = 0;
    int n_fail   = 0;
    int t_cnt;

    typedef struct {
        int          commit_t;
        logic [15:0] disp;
    } sb_t;
    sb_t sb_q[$];

    logic [15:0] m_disp = '0;
    logic [15:0] m_prev = '0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .BIN_W    (BIN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bin   (in_bin),
        .digit    (digit),
        .dig_sel  (dig_sel),
        .ovf      (ovf)
    );

    // Rising edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t_cnt <= 0;
        else        t_cnt <= t_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t_cnt);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic int idx_at(input int k);
        return (k < 0) ? 0 : (k / SCAN_DIV) % 4;
    endfunction

    function automatic logic [3:0] exp_sel(input int i, input logic [15:0] d);
        logic [3:0] s;
        s = ~(4'b0001 << i);
`ifdef LEADING_ZERO_BLANK_EN
        if (d[15:4]  == 12'd0) s[1] = 1'b1;
        if (d[15:8]  == 8'd0)  s[2] = 1'b1;
        if (d[15:12] == 4'd0)  s[3] = 1'b1;
`endif
        return s;
    endfunction

    // Display model: digit(t) = disp(t-1)[idx(t-1)], dig_sel(t) from idx(t-2).
    always @(negedge clk) begin
        if (!rst_n) begin
            m_disp = '0;
            m_prev = '0;
            sb_q.delete();
        end else begin
            m_prev = m_disp;
            if (sb_q.size() > 0 && sb_q[0].commit_t == t_cnt) begin
                m_disp = sb_q[0].disp;
                void'(sb_q.pop_front());
            end
            if (mon_en) begin
                check("digit", 32'(digit), 32'(m_prev[4*idx_at(t_cnt-1) +: 4]));
                check("dig_sel", 32'(dig_sel), 32'(exp_sel(idx_at(t_cnt-2), m_prev)));
            end
        end
    end

    // Called at a negedge; drives one accept and returns at the negedge after it.
    task automatic accept(input int val, output int n_edge);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bin   = BIN_W'(val);
        n_edge   = t_cnt + 1;
        sb_q.push_back('{n_edge + LAT, to_bcd(val)});
        @(negedge clk);
        in_valid = 1'b0;
        check("ovf", 32'(ovf), (val > 9999) ? 32'd1 : 32'd0);
    endtask

    // Called at the negedge after accept edge N; ready is low through edge N+BIN_W+1.
    task automatic ready_window();
        for (int k = 0; k <= BIN_W; k++) begin
            check("ready_busy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        check("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n;

        // Reset state while held.
        #12;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_sel", 32'(dig_sel), 32'b1110);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        #2 rst_n  = 1'b1;
        mon_en = 1'b1;

        // Idle scan: all digits zero, enables rotate.
        repeat (20) @(negedge clk);

        // 1234: ready window, then shown units-first.
        accept(1234, n);
        ready_window();
        repeat (20) @(negedge clk);

        // Overflow clamps to 9999, next accept clears it.
        accept(12000, n);
        repeat (24) @(negedge clk);
        accept(5, n);
        repeat (24) @(negedge clk);

        // in_valid held with changing data: only first value, next accept exactly at N+BIN_W+2.
        check("ready_pulse_start", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bin   = BIN_W'(7);
        n        = t_cnt + 1;
        sb_q.push_back('{n + LAT, to_bcd(7)});
        @(negedge clk);
        for (int k = 0; k <= BIN_W; k++) begin
            check("ready_pulse_busy", 32'(in_ready), 32'd0);
            in_bin = BIN_W'(200 + k);
            @(negedge clk);
        end
        check("ready_pulse_back", 32'(in_ready), 32'd1);
        check("pulse_edge", 32'(t_cnt), 32'(n + BIN_W + 1));
        in_bin = BIN_W'(4321);
        sb_q.push_back('{t_cnt + 1 + LAT, to_bcd(4321)});
        @(negedge clk);
        in_valid = 1'b0;
        check("ready_after_second", 32'(in_ready), 32'd0);
        check("ovf_pulse", 32'(ovf), 32'd0);
        repeat (40) @(negedge clk);

        // Commit edge coincides with a scan index change.
        while (t_cnt % SCAN_DIV != 0) @(negedge clk);
        accept(8642, n);
        check("wrap_align", 32'((n + LAT) % SCAN_DIV), 32'd0);
        repeat (24) @(negedge clk);

        // Reset in the middle of a conversion.
        accept(10500, n);
        repeat (4) @(negedge clk);
        check("ready_mid_conv", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_digit", 32'(digit), 32'd0);
        check("arst_sel", 32'(dig_sel), 32'b1110);
        check("arst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);
        repeat (30) @(negedge clk);
        check("ready_final", 32'(in_ready), 32'd1);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
